// File: rtl/ccff_loader.sv
// ccff_loader: streams upstream bitstream words MSB-first into a CHAIN_LEN-bit
//   configuration chain and releases IO isolation only once the full chain is loaded.
// Latency: one LOAD cycle per word, then one chain bit per cycle while shifting.
// Backpressure: s_ready is high only in LOAD; the upstream holds s_data until it is taken.
// Ports:
//   prog_clk, pReset      - clock and async active-high reset
//   start                 - one-cycle load request (honoured in IDLE and DONE only)
//   s_data/s_valid/s_ready- word handshake from the bitstream source
//   ccff_head             - serial bit into the chain head
//   ccff_shift_en         - chain shift enable (feeds the chain clock gate)
//   IO_ISOL_N             - 0 keeps IO pads isolated; 1 only after a complete load
//   busy/done             - loading / load complete
//   ones_cnt              - number of 1s shifted into the chain this load
module ccff_loader #(
   parameter int WORD_W    = 32,
   parameter int CHAIN_LEN = 1024
) (
   input  logic                           prog_clk,
   input  logic                           pReset,
   input  logic                           start,
   input  logic [WORD_W-1:0]              s_data,
   input  logic                           s_valid,
   output logic                           s_ready,
   output logic                           ccff_head,
   output logic                           ccff_shift_en,
   output logic                           IO_ISOL_N,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(CHAIN_LEN+1)-1:0] ones_cnt
);

   localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
   localparam int WCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
   localparam logic [WCNT_W-1:0] LAST_WBIT = WCNT_W'(WORD_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t             state_q;
   // sreg_q holds the bits still to be sent *after* the one on ccff_head,
   // so the head bit is always a register output.
   logic [WORD_W-1:0]  sreg_q;
   logic [WORD_W-1:0]  sreg_d;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic [WCNT_W-1:0]  wbit_cnt_q;
   logic [CNT_W-1:0]   ones_q;
   logic               s_ready_q;
   logic               head_q;
   logic               shift_en_q;
   logic               isol_n_q;
   logic               busy_q;
   logic               done_q;

   assign sreg_d = sreg_q << 1;

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state_q    <= S_IDLE;
         sreg_q     <= '0;
         bit_cnt_q  <= '0;
         wbit_cnt_q <= '0;
         ones_q     <= '0;
         s_ready_q  <= 1'b0;
         head_q     <= 1'b0;
         shift_en_q <= 1'b0;
         isol_n_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               // Restarting from DONE re-isolates the pads on the same edge.
               if (start) begin
                  state_q   <= S_LOAD;
                  bit_cnt_q <= '0;
                  ones_q    <= '0;
                  s_ready_q <= 1'b1;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  isol_n_q  <= 1'b0;
               end
            end
            S_LOAD: begin
               if (s_valid) begin
                  state_q    <= S_SHIFT;
                  head_q     <= s_data[WORD_W-1];
                  sreg_q     <= s_data << 1;
                  wbit_cnt_q <= '0;
                  s_ready_q  <= 1'b0;
                  shift_en_q <= 1'b1;
               end
            end
            S_SHIFT: begin
               sreg_q     <= sreg_d;
               bit_cnt_q  <= bit_cnt_q + 1'b1;
               wbit_cnt_q <= wbit_cnt_q + 1'b1;
               ones_q     <= ones_q + CNT_W'(head_q);
               // Chain-length exit has priority so a partial last word drops its LSBs.
               if (bit_cnt_q == LAST_BIT) begin
                  state_q    <= S_DONE;
                  head_q     <= 1'b0;
                  shift_en_q <= 1'b0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  isol_n_q   <= 1'b1;
               end else if (wbit_cnt_q == LAST_WBIT) begin
                  state_q    <= S_LOAD;
                  head_q     <= 1'b0;
                  shift_en_q <= 1'b0;
                  s_ready_q  <= 1'b1;
               end else begin
                  head_q <= sreg_q[WORD_W-1];
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign s_ready       = s_ready_q;
   assign ccff_head     = head_q;
   assign ccff_shift_en = shift_en_q;
   assign IO_ISOL_N     = isol_n_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign ones_cnt      = ones_q;

endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: drives three loader instances (chain lengths 64, 100 and 1)
//   with directed and random word streams, and compares the chain bit stream,
//   pulse count, ones count and completion timing against a bit-list model.
module tb_ccff_loader;

   localparam int CL0 = 64;
   localparam int CL1 = 100;
   localparam int CL2 = 1;

   logic        clk;
   logic        rst;
   logic        st [3];
   logic        sv [3];
   logic [31:0] sd [3];
   wire         sr [3];
   wire         hd [3];
   wire         se [3];
   wire         isn[3];
   wire         bz [3];
   wire         dn [3];
   wire [31:0]  oc [3];
   wire [6:0]   oc0;
   wire [6:0]   oc1;
   wire [0:0]   oc2;

   logic [31:0] words [4];
   int          n_chk = 0;
   int          n_err = 0;

   assign oc[0] = 32'(oc0);
   assign oc[1] = 32'(oc1);
   assign oc[2] = 32'(oc2);

   ccff_loader #(.WORD_W(32), .CHAIN_LEN(CL0)) u_dut0 (
      .prog_clk(clk), .pReset(rst), .start(st[0]), .s_data(sd[0]), .s_valid(sv[0]),
      .s_ready(sr[0]), .ccff_head(hd[0]), .ccff_shift_en(se[0]), .IO_ISOL_N(isn[0]),
      .busy(bz[0]), .done(dn[0]), .ones_cnt(oc0));

   ccff_loader #(.WORD_W(32), .CHAIN_LEN(CL1)) u_dut1 (
      .prog_clk(clk), .pReset(rst), .start(st[1]), .s_data(sd[1]), .s_valid(sv[1]),
      .s_ready(sr[1]), .ccff_head(hd[1]), .ccff_shift_en(se[1]), .IO_ISOL_N(isn[1]),
      .busy(bz[1]), .done(dn[1]), .ones_cnt(oc1));

   ccff_loader #(.WORD_W(32), .CHAIN_LEN(CL2)) u_dut2 (
      .prog_clk(clk), .pReset(rst), .start(st[2]), .s_data(sd[2]), .s_valid(sv[2]),
      .s_ready(sr[2]), .ccff_head(hd[2]), .ccff_shift_en(se[2]), .IO_ISOL_N(isn[2]),
      .busy(bz[2]), .done(dn[2]), .ones_cnt(oc2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One complete load on instance id. The expected chain content is the
   // concatenation of the words, MSB first, truncated to cl bits.
   //   gap_at/gap_len : hold s_valid low for gap_len LOAD cycles before word gap_at
   //   rnd            : random s_valid drop-outs while the loader is ready
   //   abort_at       : assert reset during this shift pulse (0 = never)
   //   start_mid      : pulse start during the 10th shift pulse
   task automatic run_load(input int id, input int cl, input int gap_at, input int gap_len,
                           input bit rnd, input int abort_at, input bit start_mid);
      bit exp_bits[$];
      int nw;
      int exp_ones;
      int pulses;
      int ones_sent;
      int head_err;
      int inv_err;
      int wi;
      int cyc;
      int gaps;
      int gap_left;
      int stray;
      bit hold;

      nw = (cl + 31) / 32;
      exp_ones = 0;
      for (int w = 0; w < nw; w++) begin
         for (int b = 31; b >= 0; b--) begin
            if (exp_bits.size() < cl) begin
               exp_bits.push_back(words[w][b]);
               exp_ones += int'(words[w][b]);
            end
         end
      end
      pulses = 0; ones_sent = 0; head_err = 0; inv_err = 0;
      wi = 0; gaps = 0; gap_left = gap_len;

      @(negedge clk);
      st[id] = 1'b1;
      sv[id] = 1'b0;
      @(negedge clk);
      cyc = 1;
      forever begin
         if (dn[id] === 1'b1) break;
         if (cyc > 2000) break;
         if (bz[id] !== 1'b1 || isn[id] !== 1'b0 || (sr[id] ^ se[id]) !== 1'b1 ||
             (se[id] !== 1'b1 && hd[id] !== 1'b0))
            inv_err++;
         if (oc[id] != 32'(ones_sent)) inv_err++;
         st[id] = 1'b0;
         if (se[id] === 1'b1) begin
            if (pulses < cl && hd[id] !== exp_bits[pulses]) head_err++;
            ones_sent += int'(hd[id]);
            pulses++;
            if (abort_at != 0 && pulses == abort_at) begin
               rst = 1'b1;
               sv[id] = 1'b0;
               #1;
               chk_eq("abort_outs", {26'd0, se[id], bz[id], sr[id], hd[id], isn[id], dn[id]}, 0);
               chk_eq("abort_ones", oc[id], 0);
               chk_eq("abort_heads", head_err, 0);
               @(negedge clk);
               rst = 1'b0;
               stray = 0;
               repeat (5) begin
                  @(negedge clk);
                  if (se[id] !== 1'b0 || bz[id] !== 1'b0 || dn[id] !== 1'b0 || isn[id] !== 1'b0)
                     stray++;
               end
               chk_eq("abort_quiet", stray, 0);
               return;
            end
            if (start_mid && pulses == 10) st[id] = 1'b1;
         end
         if (sr[id] === 1'b1) begin
            hold = (wi == gap_at && gap_left > 0) || (rnd && $urandom_range(0, 2) == 0);
            if (hold) begin
               sv[id] = 1'b0;
               gaps++;
               if (wi == gap_at && gap_left > 0) gap_left--;
            end else if (wi >= nw) begin
               inv_err++;
               sv[id] = 1'b1;
               sd[id] = $urandom;
            end else begin
               sv[id] = 1'b1;
               sd[id] = words[wi];
               wi++;
            end
         end else begin
            // Not ready: valid and data are don't-care and must be ignored.
            sv[id] = 1'($urandom_range(0, 1));
            sd[id] = $urandom;
         end
         @(negedge clk);
         cyc++;
      end
      sv[id] = 1'b0;
      st[id] = 1'b0;
      chk_eq("done_reached", {31'd0, dn[id]}, 1);
      chk_eq("done_cycle", cyc, nw + cl + 1 + gaps);
      chk_eq("shift_pulses", pulses, cl);
      chk_eq("head_errors", head_err, 0);
      chk_eq("invariant_errors", inv_err, 0);
      chk_eq("ones_cnt", oc[id], exp_ones);
      chk_eq("done_outs", {27'd0, isn[id], sr[id], se[id], hd[id], bz[id]}, 32'b10000);
      @(negedge clk);
      chk_eq("done_hold", {29'd0, dn[id], isn[id], se[id]}, 32'b110);
      chk_eq("done_hold_ones", oc[id], exp_ones);
   endtask

   initial begin
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0;
         sv[i] = 1'b0;
         sd[i] = '0;
      end
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk_eq($sformatf("reset_outs%0d", i),
                {26'd0, sr[i], hd[i], se[i], isn[i], bz[i], dn[i]}, 0);
         chk_eq($sformatf("reset_ones%0d", i), oc[i], 0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk_eq("idle_hold", {28'd0, bz[0], se[0], sr[0], dn[0]}, 0);

      // Two-word chain, valid always high.
      words[0] = 32'h8000_0001;
      words[1] = 32'hFFFF_FFFF;
      run_load(0, CL0, -1, 0, 1'b0, 0, 1'b0);
      chk_eq("ones_two_word", oc[0], 34);

      // Restart from DONE with a stray start during SHIFT.
      words[0] = $urandom;
      words[1] = $urandom;
      run_load(0, CL0, -1, 0, 1'b0, 0, 1'b1);

      // Upstream stalls 10 cycles before the second word.
      words[0] = $urandom;
      words[1] = $urandom;
      run_load(0, CL0, 1, 10, 1'b0, 0, 1'b0);

      // Partial last word.
      words[0] = 32'hFFFF_FFFF;
      words[1] = 32'hFFFF_FFFF;
      words[2] = 32'hFFFF_FFFF;
      words[3] = 32'hA000_0000;
      run_load(1, CL1, -1, 0, 1'b0, 0, 1'b0);
      chk_eq("ones_partial", oc[1], 98);

      // Single-bit chain.
      words[0] = 32'h8000_0000;
      run_load(2, CL2, -1, 0, 1'b0, 0, 1'b0);
      chk_eq("ones_single", oc[2], 1);

      // Reset in the middle of a load, then a full reload.
      words[0] = $urandom;
      words[1] = $urandom;
      run_load(0, CL0, -1, 0, 1'b0, 20, 1'b0);
      run_load(0, CL0, -1, 0, 1'b0, 0, 1'b0);

      // Random words with random upstream stalls on every chain length.
      for (int k = 0; k < 6; k++) begin
         for (int w = 0; w < 4; w++) words[w] = $urandom;
         case (k % 3)
            0:       run_load(0, CL0, -1, 0, 1'b1, 0, 1'b0);
            1:       run_load(1, CL1, -1, 0, 1'b1, 0, 1'b0);
            default: run_load(2, CL2, -1, 0, 1'b1, 0, 1'b0);
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
